fmap_buffer_hdshk: RTL and testbench

- On-chip feature-map buffer placed between a producing conv stage and the next consumer (conv2d2_mem or max_pool_mem).
- Captures the producer's out_valid/out_data stream channel-major: channel 0 pixels 0..NPIX-1, then channel 1, and so on.
- Serves the captured map to the consumer over the standard ifm_addr/ifm_chan address/data handshake.
- Replaces the behavioural ifm_mem servicers in the bench with synthesizable RTL.

---
 rtl/fmap_buffer_hdshk_if.sv | 24 ++
 rtl/fmap_buffer_hdshk.sv | 168 ++++++++++++++++
 tb/tb_fmap_buffer_hdshk.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fmap_buffer_hdshk_if.sv
// Read-side handshake bundle between the feature-map buffer (slave) and its consumer (master).
interface fmap_buffer_hdshk_if #(
    parameter int ADDR_W = 10,
    parameter int CHAN_W = 4,
    parameter int DATA_W = 16
);
    logic        [ADDR_W-1:0] ifm_addr;
    logic        [CHAN_W-1:0] ifm_chan;
    logic                     ifm_addr_valid;
    logic                     ifm_addr_ready;
    logic signed [DATA_W-1:0] ifm_data;
    logic                     ifm_data_valid;
    logic                     ifm_data_ready;

    modport master (
        output ifm_addr, ifm_chan, ifm_addr_valid, ifm_data_ready,
        input  ifm_addr_ready, ifm_data, ifm_data_valid
    );

    modport slave (
        input  ifm_addr, ifm_chan, ifm_addr_valid, ifm_data_ready,
        output ifm_addr_ready, ifm_data, ifm_data_valid
    );
endinterface

// File: rtl/fmap_buffer_hdshk.sv
// Channel-major feature-map capture buffer with a registered address/data read handshake.
// Optional build macro FMAP_BUF_RELU_EN clamps negative words to zero on capture.
module fmap_buffer_hdshk #(
    parameter int WIDTH    = 32,
    parameter int HEIGHT   = 32,
    parameter int CHANNELS = 16,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 10,
    parameter int CHAN_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [31:0]         in_data,
    input  logic                in_valid,
    output logic                full,
    output logic                overflow,
    output logic                addr_err,
    fmap_buffer_hdshk_if.slave  rd
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int DEPTH = CHANNELS * NPIX;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ACK  = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    logic        [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic        [CHAN_W-1:0] ch_cnt_q, ch_cnt_d;
    logic                     full_q, full_d;
    logic                     overflow_q, overflow_d;
    logic                     addr_err_q, addr_err_d;
    logic        [1:0]        state_q, state_d;
    logic        [ADDR_W-1:0] addr_q, addr_d;
    logic        [CHAN_W-1:0] chan_q, chan_d;
    logic signed [DATA_W-1:0] ifm_data_q, ifm_data_d;
    logic signed [DATA_W-1:0] mem_q [DEPTH];

    logic                     wr_en;
    logic        [IDX_W-1:0]  wr_idx;
    logic signed [DATA_W-1:0] wr_data;
    logic        [IDX_W-1:0]  rd_idx;
    logic                     rd_in_range;

    function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] w);
`ifdef FMAP_BUF_RELU_EN
        return w[DATA_W-1] ? '0 : w;
`else
        return w;
`endif
    endfunction

    generate
        if (DATA_W < 32) begin : g_in_hi
            logic unused_in_hi;
            assign unused_in_hi = ^in_data[31:DATA_W];
        end
    endgenerate

    // Capture: clear dominates, and a full buffer only records the overflow.
    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        ch_cnt_d   = ch_cnt_q;
        full_d     = full_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        if (clear) begin
            pix_cnt_d = '0;
            ch_cnt_d  = '0;
            full_d    = 1'b0;
        end else if (in_valid) begin
            if (full_q) begin
                overflow_d = 1'b1;
            end else begin
                wr_en = 1'b1;
                if (pix_cnt_q == ADDR_W'(NPIX - 1)) begin
                    pix_cnt_d = '0;
                    if (ch_cnt_q == CHAN_W'(CHANNELS - 1)) begin
                        ch_cnt_d = '0;
                        full_d   = 1'b1;
                    end else begin
                        ch_cnt_d = ch_cnt_q + 1'b1;
                    end
                end else begin
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        wr_idx      = IDX_W'(ch_cnt_q) * IDX_W'(NPIX) + IDX_W'(pix_cnt_q);
        wr_data     = relu(in_data[DATA_W-1:0]);
        rd_idx      = IDX_W'(chan_q) * IDX_W'(NPIX) + IDX_W'(addr_q);
        rd_in_range = (32'(addr_q) < NPIX) && (32'(chan_q) < CHANNELS);
    end

    // Read FSM: one request in flight; the memory is read during the acknowledge cycle.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        chan_d     = chan_q;
        ifm_data_d = ifm_data_q;
        addr_err_d = addr_err_q;
        case (state_q)
            R_IDLE: begin
                if (rd.ifm_addr_valid && full_q) begin
                    addr_d  = rd.ifm_addr;
                    chan_d  = rd.ifm_chan;
                    state_d = R_ACK;
                end
            end
            R_ACK: begin
                if (rd_in_range) begin
                    ifm_data_d = mem_q[rd_idx];
                end else begin
                    ifm_data_d = '0;
                    addr_err_d = 1'b1;
                end
                state_d = R_DATA;
            end
            R_DATA: begin
                if (rd.ifm_data_ready) begin
                    state_d = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_q  <= '0;
            ch_cnt_q   <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            addr_err_q <= 1'b0;
            state_q    <= R_IDLE;
            ifm_data_q <= '0;
        end else begin
            pix_cnt_q  <= pix_cnt_d;
            ch_cnt_q   <= ch_cnt_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            addr_err_q <= addr_err_d;
            state_q    <= state_d;
            ifm_data_q <= ifm_data_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        chan_q <= chan_d;
        if (wr_en && !rst) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign full              = full_q;
    assign overflow          = overflow_q;
    assign addr_err          = addr_err_q;
    assign rd.ifm_addr_ready = (state_q == R_ACK);
    assign rd.ifm_data_valid = (state_q == R_DATA);
    assign rd.ifm_data       = ifm_data_q;

endmodule

// File: tb/tb_fmap_buffer_hdshk.sv
// Randomized bench for fmap_buffer_hdshk on a 4x4x2 map, checked against a flat-array reference model.
module tb_fmap_buffer_hdshk;

    localparam int W     = 4;
    localparam int H     = 4;
    localparam int C     = 2;
    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int CW    = 2;
    localparam int NP    = W * H;
    localparam int DEPTH = C * NP;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [31:0] in_data;
    logic        in_valid;
    logic        full;
    logic        overflow;
    logic        addr_err;

    always #5 clk = ~clk;

    fmap_buffer_hdshk_if #(.ADDR_W(AW), .CHAN_W(CW), .DATA_W(DW)) bus ();

    fmap_buffer_hdshk #(
        .WIDTH(W), .HEIGHT(H), .CHANNELS(C), .DATA_W(DW), .ADDR_W(AW), .CHAN_W(CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .in_data  (in_data),
        .in_valid (in_valid),
        .full     (full),
        .overflow (overflow),
        .addr_err (addr_err),
        .rd       (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] ref_mem [DEPTH];
    logic [15:0] stim    [DEPTH];
    int          wr_ptr;
    bit          ref_full;
    bit          ref_ovf;
    bit          ref_err;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] stored(input logic [15:0] w);
`ifdef FMAP_BUF_RELU_EN
        if ($signed(w) < 0) return 16'h0;
`endif
        return w;
    endfunction

    task automatic model_reset;
        wr_ptr   = 0;
        ref_full = 1'b0;
        ref_ovf  = 1'b0;
        ref_err  = 1'b0;
    endtask

    task automatic fill(input int lo, input int hi, input bit watch_req);
        for (int i = lo; i < hi; i++) begin
            in_valid = 1'b1;
            in_data  = {16'($urandom), stim[i]};
            step;
            if (ref_full) begin
                ref_ovf = 1'b1;
            end else begin
                ref_mem[wr_ptr] = stored(stim[i]);
                wr_ptr++;
                if (wr_ptr == DEPTH) begin
                    wr_ptr   = 0;
                    ref_full = 1'b1;
                end
            end
            check_val("full_during_fill", 32'(full), 32'(ref_full));
            if (watch_req) check_val("req_held_off", 32'(bus.ifm_addr_ready), 32'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic do_read(input int ch, input int ad, input int hold, input bit chk_lat);
        logic [31:0] exp_d;
        int          lat;
        bus.ifm_chan       = ch[CW-1:0];
        bus.ifm_addr       = ad[AW-1:0];
        bus.ifm_addr_valid = 1'b1;
        bus.ifm_data_ready = 1'b0;
        lat = 0;
        do begin
            step;
            lat++;
        end while (!bus.ifm_addr_ready && lat < 64);
        check_val("addr_ready_seen", 32'(bus.ifm_addr_ready), 32'd1);
        if (chk_lat) check_val("req_latency", 32'(lat), 32'd1);
        bus.ifm_addr_valid = 1'b0;
        if (ch < C && ad < NP) begin
            exp_d = {16'h0, ref_mem[ch * NP + ad]};
        end else begin
            exp_d   = 32'd0;
            ref_err = 1'b1;
        end
        step;
        check_val("data_valid", 32'(bus.ifm_data_valid), 32'd1);
        check_val("addr_ready_single", 32'(bus.ifm_addr_ready), 32'd0);
        check_val("read_data", {16'h0, bus.ifm_data}, exp_d);
        for (int k = 0; k < hold; k++) begin
            step;
            check_val("bp_valid", 32'(bus.ifm_data_valid), 32'd1);
            check_val("bp_data", {16'h0, bus.ifm_data}, exp_d);
            check_val("bp_no_ready", 32'(bus.ifm_addr_ready), 32'd0);
        end
        bus.ifm_data_ready = 1'b1;
        step;
        bus.ifm_data_ready = 1'b0;
        check_val("valid_drop", 32'(bus.ifm_data_valid), 32'd0);
        check_val("addr_err", 32'(addr_err), 32'(ref_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        clear              = 1'b0;
        in_valid           = 1'b0;
        in_data            = 32'd0;
        bus.ifm_addr       = '0;
        bus.ifm_chan       = '0;
        bus.ifm_addr_valid = 1'b0;
        bus.ifm_data_ready = 1'b0;
        step;
        step;
        rst = 1'b0;
        model_reset();

        check_val("rst_full", 32'(full), 32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        check_val("rst_addr_err", 32'(addr_err), 32'd0);
        check_val("rst_addr_ready", 32'(bus.ifm_addr_ready), 32'd0);
        check_val("rst_data_valid", 32'(bus.ifm_data_valid), 32'd0);
        check_val("rst_data", {16'h0, bus.ifm_data}, 32'd0);

        for (int i = 0; i < DEPTH; i++) stim[i] = 16'(i);
        fill(0, DEPTH, 1'b0);
        check_val("full_after_fill", 32'(full), 32'd1);
        do_read(1, 5, 0, 1'b1);
        do_read(0, 3, 5, 1'b1);

        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        step;
        in_valid = 1'b0;
        ref_ovf  = 1'b1;
        check_val("overflow_set", 32'(overflow), 32'd1);
        check_val("full_kept", 32'(full), 32'd1);
        do_read(0, 0, 0, 1'b1);

        do_read(3, 2, 0, 1'b1);
        check_val("addr_err_chan", 32'(addr_err), 32'd1);
        do_read(1, 20, 0, 1'b1);
        do_read(1, 7, 0, 1'b1);

        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0000_1234;
        step;
        clear    = 1'b0;
        in_valid = 1'b0;
        wr_ptr   = 0;
        ref_full = 1'b0;
        check_val("clear_full", 32'(full), 32'd0);
        check_val("clear_keeps_ovf", 32'(overflow), 32'(ref_ovf));
        check_val("clear_keeps_err", 32'(addr_err), 32'(ref_err));

        for (int i = 0; i < DEPTH; i++) stim[i] = 16'($urandom);
        stim[0] = 16'hFF80;
        stim[1] = 16'h0040;
        fill(0, 10, 1'b0);
        bus.ifm_chan       = 2'd1;
        bus.ifm_addr       = 5'd4;
        bus.ifm_addr_valid = 1'b1;
        fill(10, DEPTH, 1'b1);
        do_read(1, 4, 0, 1'b1);
        do_read(0, 0, 0, 1'b1);
        do_read(0, 1, 0, 1'b1);

        repeat (24) begin
            do_read(int'($urandom_range(0, C)), int'($urandom_range(0, NP + 3)),
                    int'($urandom_range(0, 3)), 1'b1);
        end

        bus.ifm_chan       = 2'd1;
        bus.ifm_addr       = 5'd2;
        bus.ifm_addr_valid = 1'b1;
        step;
        bus.ifm_addr_valid = 1'b0;
        step;
        check_val("pre_rst_valid", 32'(bus.ifm_data_valid), 32'd1);
        rst = 1'b1;
        step;
        rst = 1'b0;
        model_reset();
        check_val("rst_rdata_valid", 32'(bus.ifm_data_valid), 32'd0);
        check_val("rst_rdata", {16'h0, bus.ifm_data}, 32'd0);
        check_val("rst_full2", 32'(full), 32'd0);
        check_val("rst_overflow2", 32'(overflow), 32'd0);
        check_val("rst_addr_err2", 32'(addr_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
